// File: rtl/mem_rw_bridge.sv
// mem_rw_bridge: burst bridge from a valid/ready request/response interface onto
// a single-cycle memory helper port (r_enable/r_index/r_data, w_enable/w_index/
// w_data/w_mask, enable).
// Byte addresses become word indices relative to BASE_ADDR; byte strobes become bit masks.
// Optional build macro MEM_BRIDGE_RANGE_CHK_EN: beats outside
// [BASE_ADDR, BASE_ADDR+MEM_BYTES) are blocked and reported through rsp_err.
module mem_rw_bridge #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned LEN_W     = 4,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter logic [63:0] MEM_BYTES = 64'h0800_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_last,
    output logic                rsp_write,
    output logic                rsp_err,
    output logic                mem_enable,
    output logic                mem_r_enable,
    output logic [ADDR_W-1:0]   mem_r_index,
    input  logic [DATA_W-1:0]   mem_r_data,
    output logic                mem_w_enable,
    output logic [ADDR_W-1:0]   mem_w_index,
    output logic [DATA_W-1:0]   mem_w_data,
    output logic [DATA_W-1:0]   mem_w_mask
);

    localparam int unsigned       STRB_W = DATA_W / 8;
    localparam int unsigned       SHIFT  = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_RD_DRAIN = 3'd2,
        S_WR       = 3'd3,
        S_WR_RSP   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    beat_r;
    logic                err_acc_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                rsp_last_r;
    logic                rsp_write_r;
    logic                rsp_err_r;

    logic [ADDR_W-1:0]   off_s;
    logic [ADDR_W-1:0]   idx_s;
    logic                in_range_s;
    logic                last_beat_s;
    logic                accept_s;
    logic                rd_issue_s;
    logic                wr_beat_s;
    logic                rsp_pop_s;

    // Each strobe bit enables one full byte lane of the memory word.
    function automatic logic [DATA_W-1:0] expand_strb(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    // Offset and index wrap modulo 2^ADDR_W; low byte-lane bits drop out in the shift.
    assign off_s       = addr_r - BASE_A;
    assign idx_s       = off_s >> SHIFT;
    assign last_beat_s = (beat_r == len_r);

`ifdef MEM_BRIDGE_RANGE_CHK_EN
    localparam logic [ADDR_W-1:0] SPAN_A = ADDR_W'(MEM_BYTES);
    assign in_range_s = (off_s < SPAN_A);
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^MEM_BYTES;
    assign in_range_s   = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and memory/handshake strobes; everything is held low in reset.
    always_comb begin
        state_nxt_s  = state_r;
        req_ready    = 1'b0;
        wd_ready     = 1'b0;
        mem_enable   = 1'b0;
        mem_r_enable = 1'b0;
        mem_r_index  = '0;
        mem_w_enable = 1'b0;
        mem_w_index  = '0;
        mem_w_data   = '0;
        mem_w_mask   = '0;
        accept_s     = 1'b0;
        rd_issue_s   = 1'b0;
        wr_beat_s    = 1'b0;
        rsp_pop_s    = 1'b0;
        if (!rst_n) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept_s    = 1'b1;
                        state_nxt_s = req_write ? S_WR : S_RD;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_RD: begin
                    mem_enable  = 1'b1;
                    mem_r_index = idx_s;
                    // A beat may only be issued if its response has somewhere to land.
                    if (!rsp_valid_r || rsp_ready) begin
                        rd_issue_s   = 1'b1;
                        mem_r_enable = in_range_s;
                        state_nxt_s  = last_beat_s ? S_RD_DRAIN : S_RD;
                    end else begin
                        state_nxt_s = S_RD;
                    end
                end
                S_RD_DRAIN: begin
                    mem_enable = 1'b1;
                    if (rsp_ready) begin
                        rsp_pop_s   = 1'b1;
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_RD_DRAIN;
                    end
                end
                S_WR: begin
                    mem_enable = 1'b1;
                    wd_ready   = 1'b1;
                    if (wd_valid) begin
                        wr_beat_s    = 1'b1;
                        mem_w_enable = in_range_s;
                        mem_w_index  = idx_s;
                        mem_w_data   = wd_data;
                        mem_w_mask   = expand_strb(wd_strb);
                        state_nxt_s  = last_beat_s ? S_WR_RSP : S_WR;
                    end else begin
                        state_nxt_s = S_WR;
                    end
                end
                S_WR_RSP: begin
                    mem_enable = 1'b1;
                    if (rsp_ready) begin
                        rsp_pop_s   = 1'b1;
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_WR_RSP;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // Burst address/beat bookkeeping and the single-entry response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r      <= '0;
            len_r       <= '0;
            beat_r      <= '0;
            err_acc_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_last_r  <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r    <= req_addr;
                len_r     <= req_len;
                beat_r    <= '0;
                err_acc_r <= 1'b0;
            end else if (rd_issue_s || wr_beat_s) begin
                addr_r    <= addr_r + STEP_A;
                beat_r    <= beat_r + LEN_W'(1);
                err_acc_r <= err_acc_r | (wr_beat_s & ~in_range_s);
            end
            if (rd_issue_s) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= in_range_s ? mem_r_data : '0;
                rsp_last_r  <= last_beat_s;
                rsp_write_r <= 1'b0;
                rsp_err_r   <= ~in_range_s;
            end else if (wr_beat_s && last_beat_s) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= '0;
                rsp_last_r  <= 1'b1;
                rsp_write_r <= 1'b1;
                rsp_err_r   <= err_acc_r | ~in_range_s;
            end else if (rsp_pop_s) begin
                rsp_valid_r <= 1'b0;
                rsp_data_r  <= '0;
                rsp_last_r  <= 1'b0;
                rsp_write_r <= 1'b0;
                rsp_err_r   <= 1'b0;
            end
        end
    end

    // Response port mirrors the response register, forced low while reset is asserted.
    always_comb begin
        if (rst_n) begin
            rsp_valid = rsp_valid_r;
            rsp_data  = rsp_data_r;
            rsp_last  = rsp_last_r;
            rsp_write = rsp_write_r;
            rsp_err   = rsp_err_r;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
            rsp_last  = 1'b0;
            rsp_write = 1'b0;
            rsp_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_rw_bridge.sv
// Testbench for mem_rw_bridge: directed vector table, randomized bursts against a
// word-array reference model, and hand-written reset / range sequences.
module tb_mem_rw_bridge;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [3:0]  req_len;
    logic        wd_valid;
    logic        wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_last;
    logic        rsp_write;
    logic        rsp_err;
    logic        mem_enable;
    logic        mem_r_enable;
    logic [63:0] mem_r_index;
    logic [63:0] mem_r_data;
    logic        mem_w_enable;
    logic [63:0] mem_w_index;
    logic [63:0] mem_w_data;
    logic [63:0] mem_w_mask;

    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [63:0] pl_data;
    logic [63:0] mem_arr [0:255];
    logic [63:0] ref_mem [0:255];
    logic [63:0] wdat [0:15];
    logic [7:0]  wstb [0:15];
    int          n_pass;
    int          n_total;

    mem_rw_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_write(rsp_write), .rsp_err(rsp_err),
        .mem_enable(mem_enable), .mem_r_enable(mem_r_enable), .mem_r_index(mem_r_index),
        .mem_r_data(mem_r_data), .mem_w_enable(mem_w_enable), .mem_w_index(mem_w_index),
        .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench memory: combinational read, masked write at the clock edge.
    assign mem_r_data = mem_arr[mem_r_index[7:0]];
    always @(posedge clk) begin
        if (pl_en) begin
            mem_arr[pl_idx] <= pl_data;
        end else if (mem_w_enable) begin
            mem_arr[mem_w_index[7:0]] <= (mem_arr[mem_w_index[7:0]] & ~mem_w_mask) |
                                         (mem_w_data & mem_w_mask);
        end
    end

    task automatic check_word(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    function automatic logic [63:0] mask_of(input logic [7:0] s);
        logic [63:0] m;
        m = 64'd0;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) m = m | (64'hFF << (8 * b));
        end
        return m;
    endfunction

    task automatic preload(input int idx, input logic [63:0] val);
        pl_en = 1'b1; pl_idx = 8'(idx); pl_data = val;
        ref_mem[idx] = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Runs one burst; the model tracks issued/accepted beats and expected memory contents.
    // mode: 0 = rsp_ready always high, 2 = rsp_ready low in burst cycle 2, 1 = random.
    task automatic run_burst(input bit wr, input logic [63:0] addr, input int len, input int mode,
                             output logic [63:0] first_idx, output logic [63:0] first_mask,
                             output logic [63:0] first_data);
        logic [63:0] base_idx, cur_idx, m;
        logic [63:0] exp_q[$];
        int issued, got, wbeat, cyc;
        bit done, rdy, wv, exp_issue, pend;
        base_idx = (addr - BASE) >> 3;
        first_idx = 64'd0; first_mask = 64'd0; first_data = 64'd0;
        issued = 0; got = 0; wbeat = 0; cyc = 0; done = 1'b0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = 4'(len);
        @(negedge clk);
        check_bit("req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!done && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                2:       rdy = (cyc != 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            wv = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp_ready = rdy;
            wd_valid  = wr && wv && (wbeat <= len);
            wd_data   = wdat[wbeat % 16];
            wd_strb   = wstb[wbeat % 16];
            @(negedge clk);
            check_bit("mem_enable", mem_enable, 1'b1);
            check_bit("req_ready_busy", req_ready, 1'b0);
            if (!wr) begin
                pend = (issued > got);
                exp_issue = (issued <= len) && (!pend || rdy);
                check_bit("rsp_valid_rd", rsp_valid, pend);
                check_bit("r_enable", mem_r_enable, exp_issue);
                check_bit("w_enable_rd", mem_w_enable, 1'b0);
                check_bit("wd_ready_rd", wd_ready, 1'b0);
                if (pend && rdy) begin
                    check_word("rd_data", rsp_data, exp_q[0]);
                    check_bit("rd_last", rsp_last, got == len);
                    check_bit("rd_write", rsp_write, 1'b0);
                    check_bit("rd_err", rsp_err, 1'b0);
                    if (got == 0) first_data = rsp_data;
                    void'(exp_q.pop_front());
                    got++;
                end
                if (exp_issue) begin
                    cur_idx = base_idx + 64'(issued);
                    check_word("r_index", mem_r_index, cur_idx);
                    if (issued == 0) first_idx = mem_r_index;
                    exp_q.push_back(ref_mem[cur_idx[7:0]]);
                    issued++;
                end
                done = (got == len + 1);
            end else begin
                check_bit("wd_ready", wd_ready, wbeat <= len);
                check_bit("w_enable", mem_w_enable, wd_valid);
                check_bit("r_enable_wr", mem_r_enable, 1'b0);
                check_bit("rsp_valid_wr", rsp_valid, wbeat == len + 1);
                if (wd_valid) begin
                    cur_idx = base_idx + 64'(wbeat);
                    m = mask_of(wd_strb);
                    check_word("w_index", mem_w_index, cur_idx);
                    check_word("w_mask", mem_w_mask, m);
                    check_word("w_data", mem_w_data, wd_data);
                    if (wbeat == 0) begin
                        first_idx = mem_w_index;
                        first_mask = mem_w_mask;
                    end
                    ref_mem[cur_idx[7:0]] = (ref_mem[cur_idx[7:0]] & ~m) | (wd_data & m);
                    wbeat++;
                end else if ((wbeat == len + 1) && rdy) begin
                    check_bit("wr_rsp_write", rsp_write, 1'b1);
                    check_bit("wr_rsp_last", rsp_last, 1'b1);
                    check_word("wr_rsp_data", rsp_data, 64'd0);
                    check_bit("wr_rsp_err", rsp_err, 1'b0);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_bit("burst_done", done, 1'b1);
        rsp_ready = 1'b0;
        wd_valid = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        int          len;
        logic [63:0] d0;
        logic [7:0]  s0;
        logic [63:0] d1;
        logic [7:0]  s1;
        int          mode;
        logic [63:0] exp_idx0;
        logic [63:0] exp_mask0;
        logic [63:0] exp_data0;
    } vec_t;

    vec_t vec [0:8];

    initial begin
        logic [63:0] fi, fm, fd;
        logic [63:0] a;
        int idx, len;
        bit wr;
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; pl_en = 1'b0; pl_idx = 8'd0; pl_data = 64'd0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_len = 4'd0;
        wd_valid = 1'b0; wd_data = 64'd0; wd_strb = 8'd0; rsp_ready = 1'b0;

        for (int i = 0; i < 256; i++) ref_mem[i] = 64'd0;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) preload(i, 64'hFFFF_FFFF_FFFF_FFFF);
            else preload(i, {$urandom, $urandom});
        end
        preload(2, 64'hDEAD_BEEF_0123_4567);

        // Outputs during reset, then idle state after release.
        @(negedge clk);
        check_bit("rst_req_ready", req_ready, 1'b0);
        check_bit("rst_mem_enable", mem_enable, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("idle_req_ready", req_ready, 1'b1);
        check_bit("idle_mem_enable", mem_enable, 1'b0);
        check_bit("idle_wd_ready", wd_ready, 1'b0);
        check_bit("idle_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;

        vec[0] = '{1'b0, 64'h8000_0010, 0, 64'd0, 8'h00, 64'd0, 8'h00, 0,
                   64'd2, 64'd0, 64'hDEAD_BEEF_0123_4567};
        vec[1] = '{1'b0, 64'h8000_0000, 3, 64'd0, 8'h00, 64'd0, 8'h00, 2,
                   64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vec[2] = '{1'b1, 64'h8000_0020, 1, 64'h1111_2222_3333_4444, 8'h0F,
                   64'h1111_2222_3333_4444, 8'hF0, 0,
                   64'd4, 64'h0000_0000_FFFF_FFFF, 64'd0};
        vec[3] = '{1'b1, 64'h8000_0040, 0, 64'h1111_2222_3333_4444, 8'h0F,
                   64'd0, 8'h00, 0, 64'd8, 64'h0000_0000_FFFF_FFFF, 64'd0};
        vec[4] = '{1'b0, 64'h8000_0040, 0, 64'd0, 8'h00, 64'd0, 8'h00, 0,
                   64'd8, 64'd0, 64'hFFFF_FFFF_3333_4444};
        vec[5] = '{1'b1, 64'h8000_0048, 0, 64'h1234_5678_9ABC_DEF0, 8'h00,
                   64'd0, 8'h00, 0, 64'd9, 64'd0, 64'd0};
        vec[6] = '{1'b0, 64'h8000_004F, 0, 64'd0, 8'h00, 64'd0, 8'h00, 0,
                   64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vec[7] = '{1'b0, 64'h8000_0020, 1, 64'd0, 8'h00, 64'd0, 8'h00, 0,
                   64'd4, 64'd0, 64'hFFFF_FFFF_3333_4444};
        vec[8] = '{1'b1, 64'h8000_0058, 15, 64'hCAFE_F00D_0000_0001, 8'hFF,
                   64'h0BAD_C0DE_5555_AAAA, 8'h3C, 1,
                   64'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};

        for (int i = 0; i < 9; i++) begin
            wdat[0] = vec[i].d0; wstb[0] = vec[i].s0;
            for (int k = 1; k < 16; k++) begin
                wdat[k] = vec[i].d1; wstb[k] = vec[i].s1;
            end
            run_burst(vec[i].wr, vec[i].addr, vec[i].len, vec[i].mode, fi, fm, fd);
            check_word("vec_idx0", fi, vec[i].exp_idx0);
            if (vec[i].wr) check_word("vec_mask0", fm, vec[i].exp_mask0);
            else check_word("vec_data0", fd, vec[i].exp_data0);
        end

        // Randomized bursts with random back-pressure, unaligned start addresses.
        for (int t = 0; t < 40; t++) begin
            wr  = 1'($urandom_range(0, 1));
            idx = $urandom_range(20, 47);
            len = $urandom_range(0, 15);
            a   = BASE + 64'(idx * 8) + 64'($urandom_range(0, 7));
            for (int k = 0; k < 16; k++) begin
                wdat[k] = {$urandom, $urandom};
                wstb[k] = 8'($urandom);
            end
            run_burst(wr, a, len, 1, fi, fm, fd);
        end

        // Reset during beat 2 of a 4-beat write.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8000_0080; req_len = 4'd3;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wd_valid = 1'b1; wd_data = 64'hA5A5_0000_0000_0000 + 64'(k); wd_strb = 8'hFF;
            @(negedge clk);
            check_bit("rstseq_w_enable", mem_w_enable, 1'b1);
            check_word("rstseq_w_index", mem_w_index, 64'(16 + k));
            ref_mem[16 + k] = wd_data;
            @(posedge clk); #1;
        end
        wd_data = 64'hA5A5_0000_0000_0002;
        rst_n = 1'b0;
        @(negedge clk);
        check_bit("rstseq_no_wen", mem_w_enable, 1'b0);
        check_bit("rstseq_wd_ready", wd_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("rstseq_outs_zero",
                  |{req_ready, wd_ready, rsp_valid, rsp_data, rsp_last, rsp_write, rsp_err,
                    mem_enable, mem_r_enable, mem_r_index, mem_w_enable, mem_w_index,
                    mem_w_data, mem_w_mask}, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("rstrel_req_ready", req_ready, 1'b1);
        check_bit("rstrel_w_enable", mem_w_enable, 1'b0);
        check_bit("rstrel_wd_ready", wd_ready, 1'b0);
        check_bit("rstrel_mem_enable", mem_enable, 1'b0);
        check_bit("rstrel_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        wd_valid = 1'b0;
        run_burst(1'b0, 64'h8000_0080, 3, 0, fi, fm, fd);
        check_word("rstseq_beat0", fd, 64'hA5A5_0000_0000_0000);

`ifdef MEM_BRIDGE_RANGE_CHK_EN
        // Beat 0 below the mapped window is blocked, beat 1 at index 0 proceeds.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h7FFF_FFF8; req_len = 4'd1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_bit("rng_b0_no_ren", mem_r_enable, 1'b0);
        check_bit("rng_b0_no_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("rng_b0_valid", rsp_valid, 1'b1);
        check_bit("rng_b0_err", rsp_err, 1'b1);
        check_word("rng_b0_data", rsp_data, 64'd0);
        check_bit("rng_b0_last", rsp_last, 1'b0);
        check_bit("rng_b1_ren", mem_r_enable, 1'b1);
        check_word("rng_b1_index", mem_r_index, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("rng_b1_valid", rsp_valid, 1'b1);
        check_bit("rng_b1_err", rsp_err, 1'b0);
        check_word("rng_b1_data", rsp_data, ref_mem[0]);
        check_bit("rng_b1_last", rsp_last, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_bit("rng_idle", req_ready, 1'b1);
        @(posedge clk); #1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_rw_bridge.md
Name: mem_rw_bridge

Overview:
- Parametrised burst bridge between a valid/ready request/response interface and the single-cycle MemRWHelper-style memory port (r_enable/r_index/r_data, w_enable/w_index/w_data/w_mask, enable).
- Converts byte addresses to word indices and byte strobes to bit masks.
- Sequences incrementing multi-beat bursts and applies back-pressure on both sides.
- Replaces ad-hoc register driving of the memory helper in the top level.

Parameters:
- DATA_W, 64: memory word width in bits; power of two, >= 8.
- ADDR_W, 64: byte-address width and memory index width.
- LEN_W, 4: burst length field width; beats = req_len+1, max 2^LEN_W.
- BASE_ADDR, 64'h8000_0000: byte address mapped to memory index 0.
- MEM_BYTES, 64'h0800_0000: mapped region size in bytes; used only by the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accept
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored
- req_len  in  LEN_W  beats minus one
- wd_valid  in  1  write-data beat valid
- wd_ready  out  1  write-data accept
- wd_data  in  DATA_W  write beat data
- wd_strb  in  DATA_W/8  byte enables
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  DATA_W  read data; 0 for write responses
- rsp_last  out  1  final beat of the burst
- rsp_write  out  1  response belongs to a write
- rsp_err  out  1  access error
- mem_enable  out  1  memory enable
- mem_r_enable  out  1  memory read strobe
- mem_r_index  out  ADDR_W  read word index
- mem_r_data  in  DATA_W  read data, combinational, valid in the same cycle as mem_r_enable
- mem_w_enable  out  1  memory write strobe; memory writes at the clk edge
- mem_w_index  out  ADDR_W  write word index
- mem_w_data  out  DATA_W  write data
- mem_w_mask  out  DATA_W  bit mask; strobe bit i is expanded to bits [8i+7:8i]

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State returns to IDLE; beat counter, address and response registers are cleared.
  - All outputs are 0, including req_ready (gated by rst_n).
  - Reset mid-burst abandons the burst; no further memory strobes are issued.
- Index: word index = (addr - BASE_ADDR) >> log2(DATA_W/8), computed modulo 2^ADDR_W. The address increments by DATA_W/8 per beat and wraps modulo 2^ADDR_W.
- mem_enable = 1 in every state except IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture addr, len and write, and clear the beat counter.
  - Next state is RD or WR.
- RD: per-beat read and response timing.
  - Issue a beat (mem_r_enable=1) only when the response register is empty or is being drained this cycle (rsp_valid&rsp_ready).
  - mem_r_data is captured into rsp_data; rsp_valid rises on the next edge.
  - rsp_last=1 on beat len.
  - Latency: request accepted at edge N, first r_enable in cycle N+1, rsp_valid from N+2.
  - With rsp_ready held high, one beat completes per cycle.
  - After the last beat is issued, go to RD_DRAIN.
- RD_DRAIN: wait for the last response handshake, then go to IDLE; req_ready stays 0 until IDLE.
- WR: per-beat write timing.
  - wd_ready=1.
  - On wd_valid&wd_ready, drive mem_w_enable=1 combinationally in the same cycle, with the current index, data and expanded mask.
  - A strobe of all zeros still pulses w_enable with mask 0.
  - After the last beat, go to WR_RSP.
- WR_RSP: rsp_valid=1, rsp_write=1, rsp_last=1, rsp_data=0; on rsp_ready go to IDLE.
- Handshake rules:
  - rsp_valid is held, with stable payload, until accepted.
  - wd_ready=0 outside WR; wd beats offered outside WR are not consumed.
  - mem_r_enable and mem_w_enable are never asserted in the same cycle.
- rsp_err is 0 unless the optional feature flags an error.

Optional Feature:
- Macro: MEM_BRIDGE_RANGE_CHK_EN.
- When defined, each beat whose address lies outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) is blocked:
  - Read beats: no mem_r_enable; the response carries rsp_data=0 and rsp_err=1, with the same timing as a normal beat.
  - Write beats: the wd beat is consumed without mem_w_enable; the burst's single write response has rsp_err=1 if any beat was out of range.
  - In-range beats of the same burst proceed normally.
- When undefined, no check is made, rsp_err is tied 0 and MEM_BYTES is unused.

Test Plan:
- Single read: preload word index 2 = 64'hDEAD_BEEF_0123_4567; req addr 0x8000_0010, len 0 -> r_index=2 one cycle after accept; rsp_data matches, rsp_last=1, rsp_err=0.
- Four-beat read at 0x8000_0000 with rsp_ready low in cycle 2 -> r_index sequence 0,1,2,3; no beat issued while the response is stalled; rsp_data stable while stalled; rsp_last only on beat 3.
- Write, len 1, strb 8'h0F then 8'hF0, data 64'h1111_2222_3333_4444 -> w_mask 64'h0000_0000_FFFF_FFFF then 64'hFFFF_FFFF_0000_0000; one response with rsp_write=1.
- Write then read back the same address with strobe 8'h0F over an initial value of all ones -> readback is 64'hFFFF_FFFF_3333_4444.
- Define MEM_BRIDGE_RANGE_CHK_EN; read at 0x7FFF_FFF8, len 1 -> beat 0 has rsp_err=1, data 0 and no r_enable; beat 1 (0x8000_0000) reads normally with rsp_err=0.
- Assert rst_n=0 during beat 2 of a 4-beat write -> next cycle all outputs 0, no further w_enable; a new request is accepted after reset is released.
